// File: rtl/tag_sender_if.sv
// Handshake bundle between the trigger/digitizer front end, the tag sender
// and the event-builder tag queue.
interface tag_sender_if #(
    parameter int DROPW = 8
);
    logic             trigger;
    logic [3:0]       digi_done;
    logic             rel;
    logic [1:0]       rel_tag;
    logic             trig_accept;
    logic [1:0]       trig_tag;
    logic             tag_valid;
    logic [1:0]       tag_out;
    logic             busy;
    logic             error;
    logic [DROPW-1:0] drop_cnt;

    modport master (
        output trigger, digi_done, rel, rel_tag,
        input  trig_accept, trig_tag, tag_valid, tag_out, busy, error, drop_cnt
    );

    modport slave (
        input  trigger, digi_done, rel, rel_tag,
        output trig_accept, trig_tag, tag_valid, tag_out, busy, error, drop_cnt
    );
endinterface

// File: rtl/tag_sender.sv
// Allocates front-end event buffers to triggers and forwards buffer tags to
// the event builder strictly in allocation order once digitization completes.
module tag_sender #(
    parameter int NBUF  = 4,
    parameter int DROPW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    tag_sender_if.slave bus
);

    typedef enum logic [1:0] {
        B_FREE = 2'd0,
        B_DIGI = 2'd1,
        B_DONE = 2'd2,
        B_SENT = 2'd3
    } buf_state_e;

    buf_state_e       buf_q [NBUF];
    buf_state_e       buf_d [NBUF];
    logic [1:0]       alloc_ptr_q, alloc_ptr_d;
    logic [1:0]       send_ptr_q, send_ptr_d;
    logic [2:0]       n_used_q, n_used_d;
    logic             trig_accept_q, trig_accept_d;
    logic [1:0]       trig_tag_q, trig_tag_d;
    logic             tag_valid_q, tag_valid_d;
    logic [1:0]       tag_out_q, tag_out_d;
    logic             error_q, error_d;
    logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;

    logic             busy_s;
    logic             accept_s;
    logic             send_s;
    logic             rel_ok_s;
    logic             err_s;

    // Per-buffer transitions, pointer/counter updates and registered outputs.
    always_comb begin
        busy_s        = (n_used_q == 3'd4);
        accept_s      = bus.trigger && !busy_s;
        send_s        = (buf_q[send_ptr_q] == B_DONE);
        rel_ok_s      = bus.rel && (buf_q[bus.rel_tag] == B_SENT);
        err_s         = 1'b0;
        alloc_ptr_d   = alloc_ptr_q;
        send_ptr_d    = send_ptr_q;
        n_used_d      = n_used_q;
        drop_cnt_d    = drop_cnt_q;

        // Each legal transition is keyed on the pre-edge state, so a buffer
        // can take at most one step per cycle.
        for (int i = 0; i < NBUF; i++) begin
            buf_d[i] = buf_q[i];
            case (buf_q[i])
                B_FREE: begin
                    if (accept_s && (alloc_ptr_q == 2'(i))) begin
                        buf_d[i] = B_DIGI;
                    end else begin
                        buf_d[i] = B_FREE;
                    end
                end
                B_DIGI: begin
                    if (bus.digi_done[i]) begin
                        buf_d[i] = B_DONE;
                    end else begin
                        buf_d[i] = B_DIGI;
                    end
                end
                B_DONE: begin
                    if (send_s && (send_ptr_q == 2'(i))) begin
                        buf_d[i] = B_SENT;
                    end else begin
                        buf_d[i] = B_DONE;
                    end
                end
                B_SENT: begin
                    if (rel_ok_s && (bus.rel_tag == 2'(i))) begin
                        buf_d[i] = B_FREE;
                    end else begin
                        buf_d[i] = B_SENT;
                    end
                end
                default: begin
                    buf_d[i] = B_FREE;
                end
            endcase
            if (bus.digi_done[i] && (buf_q[i] != B_DIGI)) begin
                err_s = 1'b1;
            end else begin
                err_s = err_s;
            end
        end

        if (bus.rel && !rel_ok_s) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end

        if (accept_s) begin
            alloc_ptr_d = alloc_ptr_q + 2'd1;
        end else begin
            alloc_ptr_d = alloc_ptr_q;
        end

        if (send_s) begin
            send_ptr_d = send_ptr_q + 2'd1;
        end else begin
            send_ptr_d = send_ptr_q;
        end

        // An accept and a release in the same cycle cancel out.
        case ({accept_s, rel_ok_s})
            2'b10:   n_used_d = n_used_q + 3'd1;
            2'b01:   n_used_d = n_used_q - 3'd1;
            default: n_used_d = n_used_q;
        endcase

        if (bus.trigger && busy_s && (drop_cnt_q != {DROPW{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + {{(DROPW-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        trig_accept_d = accept_s;
        trig_tag_d    = accept_s ? alloc_ptr_q : 2'd0;
        tag_valid_d   = send_s;
        tag_out_d     = send_s ? send_ptr_q : 2'd0;
        error_d       = error_q | err_s;
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBUF; i++) begin
                buf_q[i] <= B_FREE;
            end
            alloc_ptr_q   <= 2'd0;
            send_ptr_q    <= 2'd0;
            n_used_q      <= 3'd0;
            trig_accept_q <= 1'b0;
            trig_tag_q    <= 2'd0;
            tag_valid_q   <= 1'b0;
            tag_out_q     <= 2'd0;
            error_q       <= 1'b0;
            drop_cnt_q    <= {DROPW{1'b0}};
        end else begin
            for (int i = 0; i < NBUF; i++) begin
                buf_q[i] <= buf_d[i];
            end
            alloc_ptr_q   <= alloc_ptr_d;
            send_ptr_q    <= send_ptr_d;
            n_used_q      <= n_used_d;
            trig_accept_q <= trig_accept_d;
            trig_tag_q    <= trig_tag_d;
            tag_valid_q   <= tag_valid_d;
            tag_out_q     <= tag_out_d;
            error_q       <= error_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign bus.trig_accept = trig_accept_q;
    assign bus.trig_tag    = trig_tag_q;
    assign bus.tag_valid   = tag_valid_q;
    assign bus.tag_out     = tag_out_q;
    assign bus.busy        = busy_s;
    assign bus.error       = error_q;
    assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tag_sender.sv
// Scoreboard bench for tag_sender: a buffer-state/queue reference model
// predicts accepts and tag sends, and a monitor checks them as they appear.
module tb_tag_sender;
    localparam int DROPW = 8;
    localparam int S_FREE = 0, S_DIGI = 1, S_DONE = 2, S_SENT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tag_sender_if #(.DROPW(DROPW)) bus ();
    tag_sender #(.NBUF(4), .DROPW(DROPW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int tag;
        int due;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   m_st [4];
    int   m_next;
    int   m_pending [$];
    int   m_sent [$];
    bit   m_err;
    int   m_drop;
    exp_t exp_acc [$];
    exp_t exp_tag [$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int used_count();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_st[i] != S_FREE) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_st[i] = S_FREE;
        m_next = 0;
        m_pending.delete();
        m_sent.delete();
        m_err = 1'b0;
        m_drop = 0;
        exp_acc.delete();
        exp_tag.delete();
    endtask

    // Reference: apply one clock edge worth of inputs to the buffer model.
    task automatic model_step(bit trig, logic [3:0] dd, bit rel, int rtag);
        int  nst [4];
        int  snd;
        int  newtag;
        bit  acc;
        nst = m_st;
        acc = trig && (used_count() != 4);
        newtag = m_next;
        if (acc) begin
            nst[m_next] = S_DIGI;
            exp_acc.push_back('{tag: m_next, due: cyc + 1});
            m_next = (m_next + 1) % 4;
        end else if (trig && m_drop < 255) begin
            m_drop++;
        end
        for (int i = 0; i < 4; i++) begin
            if (dd[i]) begin
                if (m_st[i] == S_DIGI) nst[i] = S_DONE;
                else m_err = 1'b1;
            end
        end
        if (m_pending.size() > 0 && m_st[m_pending[0]] == S_DONE) begin
            snd = m_pending.pop_front();
            nst[snd] = S_SENT;
            m_sent.push_back(snd);
            exp_tag.push_back('{tag: snd, due: cyc + 1});
        end
        if (rel) begin
            if (m_st[rtag] == S_SENT) begin
                nst[rtag] = S_FREE;
                for (int k = 0; k < m_sent.size(); k++) begin
                    if (m_sent[k] == rtag) begin
                        m_sent.delete(k);
                        break;
                    end
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (acc) m_pending.push_back(newtag);
        m_st = nst;
    endtask

    task automatic cycle(bit trig, logic [3:0] dd, bit rel, int rtag);
        bus.trigger   = trig;
        bus.digi_done = dd;
        bus.rel       = rel;
        bus.rel_tag   = rtag[1:0];
        model_step(trig, dd, rel, rtag);
        @(negedge clk);
        check("busy", int'(bus.busy), int'(used_count() == 4));
        check("error", int'(bus.error), int'(m_err));
        check("drop_cnt", int'(bus.drop_cnt), m_drop);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, 1'b0, 0);
    endtask

    task automatic check_all_zero(string name);
        check({name, "_trig_accept"}, int'(bus.trig_accept), 0);
        check({name, "_trig_tag"}, int'(bus.trig_tag), 0);
        check({name, "_tag_valid"}, int'(bus.tag_valid), 0);
        check({name, "_tag_out"}, int'(bus.tag_out), 0);
        check({name, "_busy"}, int'(bus.busy), 0);
        check({name, "_error"}, int'(bus.error), 0);
        check({name, "_drop_cnt"}, int'(bus.drop_cnt), 0);
    endtask

    task automatic clear_inputs();
        bus.trigger   = 1'b0;
        bus.digi_done = 4'b0000;
        bus.rel       = 1'b0;
        bus.rel_tag   = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic random_cycles(int n, bit inject_err);
        bit         trig;
        logic [3:0] dd;
        bit         rel;
        int         rtag;
        int         t;
        for (int c = 0; c < n; c++) begin
            trig = ($urandom_range(0, 99) < 50);
            dd = 4'b0000;
            for (int i = 0; i < 4; i++)
                if (m_st[i] == S_DIGI && $urandom_range(0, 99) < 40) dd[i] = 1'b1;
            rel = 1'b0;
            rtag = 0;
            if (m_sent.size() > 0 && $urandom_range(0, 99) < 40) begin
                rel = 1'b1;
                rtag = m_sent[0];
            end
            if (inject_err && $urandom_range(0, 99) < 5) begin
                t = int'($urandom_range(0, 3));
                if (!rel && m_st[t] != S_SENT) begin
                    rel = 1'b1;
                    rtag = t;
                end else if (m_st[t] != S_DIGI) begin
                    dd[t] = 1'b1;
                end
            end
            cycle(trig, dd, rel, rtag);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_acc.size() > 0 && exp_acc[0].due < cyc) begin
                mon_e = exp_acc.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL trig_accept_missing: got none, expected tag %0d at cycle %0d", mon_e.tag, mon_e.due);
            end
            while (exp_tag.size() > 0 && exp_tag[0].due < cyc) begin
                mon_e = exp_tag.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL tag_valid_missing: got none, expected tag %0d at cycle %0d", mon_e.tag, mon_e.due);
            end
            if (bus.trig_accept) begin
                if (exp_acc.size() == 0 || exp_acc[0].due != cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL trig_accept_unexpected: got tag %0d at cycle %0d, expected no accept", bus.trig_tag, cyc);
                end else begin
                    mon_e = exp_acc.pop_front();
                    check("trig_tag", int'(bus.trig_tag), mon_e.tag);
                end
            end
            if (bus.tag_valid) begin
                if (exp_tag.size() == 0 || exp_tag[0].due != cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL tag_valid_unexpected: got tag %0d at cycle %0d, expected no tag", bus.tag_out, cyc);
                end else begin
                    mon_e = exp_tag.pop_front();
                    check("tag_out", int'(bus.tag_out), mon_e.tag);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // First trigger, digitization, minimum-latency tag send.
        cycle(1'b1, 4'b0000, 1'b0, 0);
        idle(1);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        idle(3);

        // Fill all buffers, drop a fifth trigger, recycle tag 0.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0000, 1'b0, 0);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        idle(2);
        cycle(1'b0, 4'b0000, 1'b1, 0);
        cycle(1'b1, 4'b0000, 1'b0, 0);
        idle(2);

        // Out-of-order completion still yields in-order tags.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0000, 1'b0, 0);
        cycle(1'b0, 4'b0100, 1'b0, 0);
        cycle(1'b0, 4'b0010, 1'b0, 0);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        idle(4);

        // Busy with simultaneous trigger and valid release.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, 1'b0, 0);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        idle(2);
        cycle(1'b1, 4'b0000, 1'b1, 0);
        cycle(1'b1, 4'b0000, 1'b0, 0);
        idle(2);

        // Random traffic without protocol errors.
        do_reset();
        random_cycles(400, 1'b0);

        // Protocol errors: release a FREE buffer, DigiDone on a SENT buffer.
        do_reset();
        cycle(1'b1, 4'b0000, 1'b0, 0);
        cycle(1'b0, 4'b0000, 1'b1, 2);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        idle(2);
        cycle(1'b0, 4'b0001, 1'b0, 0);
        random_cycles(300, 1'b1);

        // Asynchronous reset between edges with two tags pending.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0000, 1'b0, 0);
        cycle(1'b0, 4'b0110, 1'b0, 0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        bus.trigger   = 1'b1;
        bus.digi_done = 4'b1111;
        bus.rel       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        clear_inputs();
        rst_n = 1'b1;
        idle(6);
        cycle(1'b1, 4'b0000, 1'b0, 0);
        idle(3);

        check("acc_queue_drained", exp_acc.size(), 0);
        check("tag_queue_drained", exp_tag.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tag_sender.md
TAG_SENDER -- requirements
Module: tag_sender

Interface
REQ-001 Parameter NBUF, 4, number of front-end event buffers; tag width fixed at 2 bits, so NBUF=4 is the only supported value.
REQ-002 Parameter DROPW, 8, width of the saturating dropped-trigger counter.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of Clock.
REQ-005 Trigger  input  1  one-cycle trigger strobe requesting a buffer.
REQ-006 DigiDone  input  4  one-hot per-buffer pulse: digitization of buffer [i] complete.
REQ-007 Release  input  1  one-cycle strobe: event builder has finished with buffer ReleaseTag.
REQ-008 ReleaseTag  input  2  tag of the buffer being released, qualified by Release.
REQ-009 TrigAccept  output  1  one-cycle pulse: trigger accepted and buffer allocated.
REQ-010 TrigTag  output  2  tag allocated to the accepted trigger, valid with TrigAccept.
REQ-011 TagValid  output  1  one-cycle strobe to the event-builder tag queue write enable.
REQ-012 TagOut  output  2  buffer-ready tag, valid with TagValid.
REQ-013 Busy  output  1  all NBUF buffers in use.
REQ-014 Error  output  1  sticky protocol-error flag.
REQ-015 DropCnt  output  DROPW  saturating count of triggers rejected while Busy.

Function
REQ-016 Each buffer has a 2-bit state: FREE, DIGI (digitizing), DONE (ready, tag not yet sent), SENT (tag sent, awaiting release).
REQ-017 The block keeps a 2-bit allocPtr, a 2-bit sendPtr (both wrap 3->0), and a 3-bit nUsed counter (0..4).
REQ-018 Busy = (nUsed == 4), driven combinationally from the registered nUsed.
REQ-019 Trigger with Busy=0 at edge n: buffer[allocPtr] goes FREE->DIGI, allocPtr increments, nUsed increments, and TrigAccept=1, TrigTag=old allocPtr during cycle n+1 only.
REQ-020 Trigger with Busy=1: no allocation, TrigAccept stays 0, DropCnt increments and saturates at all-ones.
REQ-021 DigiDone[i] with buffer i in DIGI: buffer i goes to DONE at that edge; DigiDone[i] for a buffer not in DIGI is ignored for state and sets Error.
REQ-022 Tags are sent strictly in allocation order: when buffer[sendPtr] is DONE, the next edge sets TagValid=1, TagOut=sendPtr for one cycle, moves the buffer to SENT, and increments sendPtr.
REQ-023 At most one tag is sent per cycle; back-to-back DONE buffers produce TagValid on consecutive cycles.
REQ-024 A buffer that is DONE while an older buffer is still DIGI waits; its tag is never sent out of order.
REQ-025 Release with buffer[ReleaseTag] in SENT: that buffer goes to FREE and nUsed decrements; Release for a buffer in any other state is ignored and sets Error.
REQ-026 Simultaneous accepted Trigger and valid Release: nUsed is unchanged, both state updates apply, and the released buffer is not reusable by this same trigger (Busy is evaluated from the pre-edge nUsed).
REQ-027 Minimum latency from DigiDone to TagValid is 2 cycles (DONE registered at edge n, TagValid high during cycle n+2).
REQ-028 Error is sticky until Reset; it never blocks normal operation.

Reset
REQ-029 While Reset=0: every buffer is FREE, allocPtr=sendPtr=0, nUsed=0, TrigAccept=0, TrigTag=0, TagValid=0, TagOut=0, Busy=0, Error=0, DropCnt=0.
REQ-030 Reset asserted mid-operation discards all pending tags with no partial TagValid; the first trigger after release of Reset gets tag 0.
REQ-031 Inputs are ignored while Reset=0.

Verification
REQ-032 Reset release, then Trigger, DigiDone=4'b0001 two cycles later -> TrigAccept/TrigTag=0 at n+1, TagValid/TagOut=0 exactly 2 cycles after DigiDone.
REQ-033 Four triggers, no releases, then a fifth -> Busy=1 after the fourth, fifth rejected, DropCnt=1; after Release of tag 0 the next Trigger gets TrigTag=0.
REQ-034 Triggers for tags 0,1,2; DigiDone order 2,1,0 -> TagValid on three consecutive cycles with TagOut 0,1,2.
REQ-035 Release of a FREE buffer, then DigiDone for a buffer in SENT -> Error=1 both times, states and nUsed unchanged, and Error held through subsequent traffic.
REQ-036 Busy=1 with same-cycle Trigger and valid Release -> trigger dropped (DropCnt+1), nUsed=3, Busy=0 next cycle.
REQ-037 Reset asserted asynchronously between clock edges with two tags pending -> all outputs are 0 immediately, and no TagValid is issued after Reset is deasserted.
